// File: rtl/adder_pkg.sv
// Shared types and constants for the accumulating adder: FSM encoding,
// hex segment table ({g,f,e,d,c,b,a}, active-high) and parameter legality check.
package adder_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic bit width_ok(input int w);
        return (w >= 4) && ((w % 4) == 0);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to seven-segment decoder. Purely combinational, no backpressure.
module hex7seg
    import adder_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/accum_adder.sv
// Key-driven add/subtract with accumulate: debounced key steps A-entry, B-entry/compute, show.
// Result registered one cycle after the accepted key press; displays decode combinationally.
module accum_adder
    import adder_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int DEBOUNCE = 16,
    localparam int DIGITS   = WIDTH / 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  k,
    input  logic                  mode,
    input  logic                  acc,
    input  logic [WIDTH-1:0]      in,
    output logic [WIDTH-1:0]      result,
    output logic                  Co,
    output logic                  ovf,
    output logic [1:0]            state,
    output logic                  valid,
    output logic [7*DIGITS-1:0]   seg_sum,
    output logic [6:0]            seg_carry
);

    localparam int CW = $clog2(DEBOUNCE);

    if (!width_ok(WIDTH) || DEBOUNCE < 2) begin : g_bad_param
        $error("accum_adder: WIDTH must be a multiple of 4 >= 4 and DEBOUNCE >= 2");
    end

    // Reset asserts asynchronously but is released in step with the clock.
    logic rst_meta, rst_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    logic          k_meta, k_sync, k_deb, kout;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            k_meta <= 1'b0;
            k_sync <= 1'b0;
            k_deb  <= 1'b0;
            cnt    <= '0;
            kout   <= 1'b0;
        end else begin
            k_meta <= k;
            k_sync <= k_meta;
            kout   <= 1'b0;
            if (k_sync == k_deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                cnt   <= '0;
                k_deb <= k_sync;
                kout  <= k_sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    state_t cur, nxt;
    logic   load_a, cap_b, load_chain;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) cur <= S_A;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        if (kout) begin
            case (cur)
                S_A:     nxt = S_B;
                S_B:     nxt = S_SHOW;
                S_SHOW:  nxt = acc ? S_B : S_A;
                default: nxt = S_A;
            endcase
        end
    end

    always_comb begin
        load_a     = kout && (cur == S_A);
        cap_b      = kout && (cur == S_B);
        load_chain = kout && (cur == S_SHOW) && acc;
    end

    assign state = cur;

    // Subtraction reuses the adder as R + ~in + 1, so Co means "no borrow".
    logic [WIDTH-1:0] r, op_b;
    logic [WIDTH:0]   sum;
    logic             ovf_nxt;

    always_comb begin
        op_b    = mode ? ~in : in;
        sum     = {1'b0, r} + {1'b0, op_b} + (WIDTH+1)'(mode);
        ovf_nxt = (r[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != r[WIDTH-1]);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r      <= '0;
            result <= '0;
            Co     <= 1'b0;
            ovf    <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= cap_b;
            if (load_a)          r <= in;
            else if (load_chain) r <= result;
            if (cap_b) begin
                result <= sum[WIDTH-1:0];
                Co     <= sum[WIDTH];
                ovf    <= ovf_nxt;
            end
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        hex7seg u_hex (
            .nibble (result[4*d +: 4]),
            .seg    (seg_sum[7*d +: 7])
        );
    end

    hex7seg u_carry (
        .nibble ({3'b000, Co}),
        .seg    (seg_carry)
    );

endmodule
